// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Brief    : Round-robin arbiter for the register bank write port (ALU / LSU),
//            with a per-register pending-write scoreboard for hazard stalls.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  input  logic              sb_set_en,
  input  logic [ADDR_W-1:0] sb_set_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data,
  output logic              idle,
  output logic              err_sticky
);

  logic                r_rr_ptr;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NUM_REGS-1:0] r_busy;
  logic                r_err;

  logic                w_alu_ready;
  logic                w_lsu_ready;
  logic                w_alu_xfer;
  logic                w_lsu_xfer;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic                w_err_set;
  logic                w_err_clr;

  // Only one side is ever ready while both are valid, so transfers are exclusive.
  assign w_alu_ready = !lsu_valid | (r_rr_ptr == 1'b0);
  assign w_lsu_ready = !alu_valid | (r_rr_ptr == 1'b1);
  assign w_alu_xfer  = alu_valid & w_alu_ready;
  assign w_lsu_xfer  = lsu_valid & w_lsu_ready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rr_ptr <= 1'b0;
      r_we     <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_we <= w_alu_xfer | w_lsu_xfer;
      if (w_alu_xfer) begin
        r_rr_ptr <= 1'b1;
        r_waddr  <= alu_addr;
        r_wdata  <= alu_data;
      end else if (w_lsu_xfer) begin
        r_rr_ptr <= 1'b0;
        r_waddr  <= lsu_addr;
        r_wdata  <= lsu_data;
      end
    end
  end

  // Set is applied after clear so a same-cycle set on the committing register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_we) begin
      w_busy_nxt[r_waddr] = 1'b0;
    end
    if (sb_set_en) begin
      w_busy_nxt[sb_set_addr] = 1'b1;
    end
  end

  assign w_err_set = sb_set_en & r_busy[sb_set_addr]
                   & !(r_we & (r_waddr == sb_set_addr));
  assign w_err_clr = r_we & !r_busy[r_waddr];

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_err_set | w_err_clr) begin
        r_err <= 1'b1;
      end
    end
  end

  assign alu_ready      = w_alu_ready;
  assign lsu_ready      = w_lsu_ready;
  assign rd_busy_a      = r_busy[rd_addr_a];
  assign rd_busy_b      = r_busy[rd_addr_b];
  assign reg_write_en   = r_we;
  assign reg_write_addr = r_waddr;
  assign reg_write_data = r_wdata;
  assign idle           = (r_busy == '0) & !r_we;
  assign err_sticky     = r_err;

endmodule
`default_nettype wire
